reg_file_sb: RTL

- Parametrised register file with a per-register scoreboard and optional write-back forwarding.
- Serves the next-generation CPU core: the decode stage reads operands and reserves a destination register; write-back writes results and releases the reservation.
- Generalises the existing 8x16 register file in width, depth, zero-register mode and forwarding.
- Adds hazard detection so decode can stall.

---
 rtl/reg_file_sb.sv | 107 ++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with per-register busy scoreboard and write-back forwarding
module reg_file_sb #(
   parameter int WIDTH    = 16,
   parameter int NREGS    = 8,
   parameter int ZERO_REG = 1,
   parameter int FWD      = 1,
   parameter int ADDR_W   = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [WIDTH-1:0]  rs1_data,
   output logic [WIDTH-1:0]  rs2_data,
   output logic              rs1_hazard,
   output logic              rs2_hazard,
   input  logic              rsv_valid,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              rsv_ready,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [WIDTH-1:0]  wb_data,
   output logic [ADDR_W:0]   busy_count
);

   localparam int DEPTH = 1 << ADDR_W;

   // Addresses that hold real state; out-of-range and the hard-wired zero register are excluded.
   function automatic logic [DEPTH-1:0] valid_mask();
      logic [DEPTH-1:0] m;
      for (int i = 0; i < DEPTH; i++) begin
         m[i] = (i < NREGS) && !((ZERO_REG != 0) && (i == 0));
      end
      return m;
   endfunction

   localparam logic [DEPTH-1:0] VALID = valid_mask();

   logic [WIDTH-1:0]  regs_q [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [ADDR_W:0]   count_q, count_d;

   logic [ADDR_W-1:0] rd_addr [2];
   logic [WIDTH-1:0]  rd_data [2];
   logic [1:0]        rd_haz;
   logic [1:0]        fwd_hit;

   logic wb_en, rsv_en, set_new, clr_old;

   assign rd_addr[0] = rs1_addr;
   assign rd_addr[1] = rs2_addr;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         fwd_hit[p] = (FWD != 0) && wb_valid && (wb_addr == rd_addr[p]) && VALID[rd_addr[p]];
         rd_data[p] = '0;
         rd_haz[p]  = 1'b0;
         if (VALID[rd_addr[p]]) begin
            rd_data[p] = fwd_hit[p] ? wb_data : regs_q[rd_addr[p]];
            rd_haz[p]  = busy_q[rd_addr[p]] & ~fwd_hit[p];
         end
      end
   end

   assign rs1_data   = rd_data[0];
   assign rs2_data   = rd_data[1];
   assign rs1_hazard = rd_haz[0];
   assign rs2_hazard = rd_haz[1];

   assign rsv_ready = ~busy_q[rsv_addr] | (wb_valid & (wb_addr == rsv_addr));
   assign wb_en     = wb_valid & VALID[wb_addr];
   assign rsv_en    = rsv_valid & rsv_ready & VALID[rsv_addr];

   // A same-address reserve and write-back leaves the register busy, so the clear does not count.
   assign set_new = rsv_en & ~busy_q[rsv_addr];
   assign clr_old = wb_en & busy_q[wb_addr] & ~(rsv_en & (rsv_addr == wb_addr));

   always_comb begin
      busy_d = busy_q;
      if (wb_en) begin
         busy_d[wb_addr] = 1'b0;
      end
      if (rsv_en) begin
         busy_d[rsv_addr] = 1'b1;
      end
      count_d = count_q + {{ADDR_W{1'b0}}, set_new} - {{ADDR_W{1'b0}}, clr_old};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
         if (wb_en) begin
            regs_q[wb_addr] <= wb_data;
         end
      end
   end

   assign busy_count = count_q;

endmodule
